// File: rtl/ct_spsram_2048x144_ctrl_pkg.sv
// ct_spsram_2048x144_ctrl_pkg: controller state encoding and SRAM pin polarity constants
package ct_spsram_2048x144_ctrl_pkg;
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;
    localparam logic CEN_ON     = 1'b0;
    localparam logic GWEN_WR    = 1'b0;
    localparam logic WEN_BIT_ON = 1'b0;
endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// ct_spsram_rsp_fifo: in-order read response FIFO with registered head entry
module ct_spsram_rsp_fifo #(
    parameter int DATA_WIDTH = 144,
    parameter int DEPTH      = 3,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  vld,
    output logic [CW-1:0]         cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    always_comb begin
        head = mem[rd_ptr];
        vld  = cnt != '0;
    end
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            assert (!(push && !pop && cnt == CW'(DEPTH)));
            assert (!(pop && cnt == '0));
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/ct_spsram_2048x144_ctrl.sv
// ct_spsram_2048x144_ctrl: valid/ready front end for the 2048x144 SRAM, zero-fills the array after reset
module ct_spsram_2048x144_ctrl
    import ct_spsram_2048x144_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 144,
    parameter int RSP_DEPTH  = 3,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    ctrl_state_e           state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  started, rd_inflight, accept, wr_acc, init_wr, fifo_pop;
    logic [CW-1:0]         fifo_cnt;
    // credits come only from registered state, so rsp_rdy never reaches req_rdy in the same cycle
    always_comb begin
        init_wr   = state == ST_INIT && started;
        req_rdy   = init_done && (int'(fifo_cnt) + int'(rd_inflight) < RSP_DEPTH);
        accept    = req_vld && req_rdy;
        wr_acc    = accept && req_wr;
        fifo_pop  = rsp_vld && rsp_rdy;
        sram_cen  = (init_wr || accept) ? CEN_ON : ~CEN_ON;
        sram_gwen = (init_wr || wr_acc) ? GWEN_WR : ~GWEN_WR;
        sram_wen  = init_wr ? {DATA_WIDTH{WEN_BIT_ON}} :
                    wr_acc  ? (WEN_BIT_ON ? req_wmask : ~req_wmask) : {DATA_WIDTH{~WEN_BIT_ON}};
        sram_a    = init_wr ? init_cnt : accept ? req_addr : '0;
        sram_d    = accept ? req_wdata : '0;
    end
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state       <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt    <= '0;
            started     <= 1'b0;
            init_done   <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            started     <= 1'b1;
            rd_inflight <= accept && !req_wr;
            init_done   <= state == ST_RUN || (init_wr && &init_cnt);
            if (init_wr) begin
                init_cnt <= init_cnt + 1'b1;
                if (&init_cnt) state <= ST_RUN;
            end
        end
    end
    ct_spsram_rsp_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RSP_DEPTH)
    ) u_rsp_fifo (
        .forever_cpuclk(forever_cpuclk),
        .cpurst_b      (cpurst_b),
        .push          (rd_inflight),
        .push_data     (sram_q),
        .pop           (fifo_pop),
        .head          (rsp_rdata),
        .vld           (rsp_vld),
        .cnt           (fifo_cnt)
    );
endmodule
